irq_ctrl: RTL and testbench

Interrupt controller that sits on the consuming end of the peripheral irq/ack interface used by timer0 and the other I/O blocks. It collects up to N_IRQ level interrupt lines and masks them. It arbitrates by fixed priority, presents one vector to the CPU core through a req/take handshake, and returns a one-cycle ack pulse to the winning source. It also exposes control and status registers on the 6-bit I/O bus.

---
 rtl/irq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_irq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: masks N_IRQ level sources, hands one vector to the
// core over a req/take handshake, acks the winner, and exposes ICR/IMR/IPR/IVR on the I/O bus.
// Optional nested servicing (two-deep active stack) is enabled by defining IRQ_NEST_EN.
module irq_ctrl #(
    parameter int          N_IRQ     = 8,
    parameter logic [5:0]  base_addr = 6'h20
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [5:0]       io_a,
    input  logic             io_we,
    input  logic             io_re,
    input  logic [7:0]       io_di,
    output logic [7:0]       io_do,
    input  logic [N_IRQ-1:0] irq_in,
    output logic [N_IRQ-1:0] irq_ack,
    output logic             cpu_irq_req,
    output logic [2:0]       cpu_irq_vec,
    input  logic             cpu_irq_take,
    input  logic             cpu_reti
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [5:0] ADDR_ICR = base_addr;
    localparam logic [5:0] ADDR_IMR = base_addr + 6'd1;
    localparam logic [5:0] ADDR_IPR = base_addr + 6'd2;
    localparam logic [5:0] ADDR_IVR = base_addr + 6'd3;
`ifdef IRQ_NEST_EN
    localparam logic [1:0] MAX_DEPTH = 2'd2;
`endif

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_idx = 3'(i);
        end
    endfunction

    state_e             state_q, state_d;
    logic               gie_q, gie_d;
    logic [N_IRQ-1:0]   imr_q, imr_d;
    logic               req_q, req_d;
    logic [2:0]         vec_q, vec_d;
    logic [N_IRQ-1:0]   ack_q, ack_d;
    logic [7:0]         io_do_q, io_do_d;
    logic [2:0]         stk0_q, stk0_d;
    logic [2:0]         stk1_q, stk1_d;
    logic [1:0]         depth_q, depth_d;

    logic [7:0]         qual8_s;
    logic [7:0]         imr8_s;
    logic [7:0]         onehot8_s;
    logic [2:0]         win_s;
    logic [2:0]         top_s;
    logic [2:0]         active_vec_s;
    logic               busy_s;
    logic               wr_icr_s;
    logic               wr_imr_s;

    // Zero-extend mask and qualified requests to the 8-bit bus width.
    always_comb begin
        qual8_s                = 8'h00;
        imr8_s                 = 8'h00;
        qual8_s[N_IRQ-1:0]     = irq_in & imr_q;
        imr8_s[N_IRQ-1:0]      = imr_q;
    end

    assign win_s        = lowest_idx(qual8_s);
    assign onehot8_s    = 8'h01 << vec_q;
    assign top_s        = (depth_q == 2'd2) ? stk1_q : stk0_q;
    assign busy_s       = (depth_q != 2'd0);
    assign active_vec_s = busy_s ? top_s : 3'd0;
    assign wr_icr_s     = io_we && (io_a == ADDR_ICR);
    assign wr_imr_s     = io_we && (io_a == ADDR_IMR);

    // Arbitration FSM, GIE/IMR updates and active-stack maintenance.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        vec_d   = vec_q;
        ack_d   = '0;
        stk0_d  = stk0_q;
        stk1_d  = stk1_q;
        depth_d = depth_q;
        gie_d   = wr_icr_s ? io_di[7] : gie_q;
        imr_d   = wr_imr_s ? io_di[N_IRQ-1:0] : imr_q;

        case (state_q)
            ST_IDLE: begin
                if (gie_q && (qual8_s != 8'h00)) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    vec_d   = win_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cpu_irq_take) begin
                    // Hardware GIE clear overrides a same-cycle ICR write.
                    ack_d   = onehot8_s[N_IRQ-1:0];
                    gie_d   = 1'b0;
                    req_d   = 1'b0;
                    state_d = ST_SERVICE;
                    depth_d = depth_q + 2'd1;
                    if (depth_q == 2'd0) begin
                        stk0_d = vec_q;
                    end else begin
                        stk1_d = vec_q;
                    end
                end else if (!qual8_s[vec_q] || !gie_q) begin
                    req_d   = 1'b0;
                    state_d = (depth_q != 2'd0) ? ST_SERVICE : ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (cpu_reti) begin
                    gie_d   = 1'b1;
                    depth_d = depth_q - 2'd1;
                    state_d = (depth_q == 2'd2) ? ST_SERVICE : ST_IDLE;
`ifdef IRQ_NEST_EN
                end else if (gie_q && (qual8_s != 8'h00) && (win_s < top_s) &&
                             (depth_q < MAX_DEPTH)) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    vec_d   = win_s;
`endif
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Register read mux; io_do is zero on any cycle without a matching read.
    always_comb begin
        io_do_d = 8'h00;
        if (io_re) begin
            case (io_a)
                ADDR_ICR: io_do_d = {gie_q, 7'd0};
                ADDR_IMR: io_do_d = imr8_s;
                ADDR_IPR: io_do_d = qual8_s;
                ADDR_IVR: io_do_d = {busy_s, 4'd0, active_vec_s};
                default:  io_do_d = 8'h00;
            endcase
        end else begin
            io_do_d = 8'h00;
        end
    end

    // State registers with asynchronous reset; reset also cancels a pending ack.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            gie_q   <= 1'b0;
            imr_q   <= '0;
            req_q   <= 1'b0;
            vec_q   <= 3'd0;
            ack_q   <= '0;
            io_do_q <= 8'h00;
            stk0_q  <= 3'd0;
            stk1_q  <= 3'd0;
            depth_q <= 2'd0;
        end else begin
            state_q <= state_d;
            gie_q   <= gie_d;
            imr_q   <= imr_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            ack_q   <= ack_d;
            io_do_q <= io_do_d;
            stk0_q  <= stk0_d;
            stk1_q  <= stk1_d;
            depth_q <= depth_d;
        end
    end

    assign io_do       = io_do_q;
    assign irq_ack     = ack_q;
    assign cpu_irq_req = req_q;
    assign cpu_irq_vec = vec_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed vector table, reset/nesting sequences and
// randomized traffic compared against a queue-based reference model.
module tb_irq_ctrl;

    localparam logic [5:0] A_ICR = 6'h20;
    localparam logic [5:0] A_IMR = 6'h21;
    localparam logic [5:0] A_IPR = 6'h22;
    localparam logic [5:0] A_IVR = 6'h23;
`ifdef IRQ_NEST_EN
    localparam int MAXD = 2;
`else
    localparam int MAXD = 1;
`endif

    logic       sys_clk, sys_rst;
    logic [5:0] io_a;
    logic       io_we, io_re;
    logic [7:0] io_di, io_do, irq_in, irq_ack;
    logic       cpu_irq_req, cpu_irq_take, cpu_reti;
    logic [2:0] cpu_irq_vec;

    int n_cmp = 0;
    int n_bad = 0;

    irq_ctrl dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .io_a(io_a), .io_we(io_we), .io_re(io_re), .io_di(io_di), .io_do(io_do),
        .irq_in(irq_in), .irq_ack(irq_ack),
        .cpu_irq_req(cpu_irq_req), .cpu_irq_vec(cpu_irq_vec),
        .cpu_irq_take(cpu_irq_take), .cpu_reti(cpu_reti)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference model state: pending request flag/vector and a queue of vectors in service.
    bit         m_gie;
    logic [7:0] m_imr;
    bit         m_pend;
    int         m_vec;
    int         m_stk[$];
    logic [7:0] m_ack;
    logic [7:0] m_do;

    typedef struct packed {
        logic [5:0] a;
        logic       we;
        logic       re;
        logic [7:0] di;
        logic [7:0] irq;
        logic       take;
        logic       reti;
        logic       exp_req;
        logic [2:0] exp_vec;
        logic [7:0] exp_ack;
        logic [7:0] exp_do;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [5:0] a, logic we, logic re, logic [7:0] di,
                                logic [7:0] irq, logic take, logic reti, logic exp_req,
                                logic [2:0] exp_vec, logic [7:0] exp_ack, logic [7:0] exp_do);
        vec_t v;
        v = {a, we, re, di, irq, take, reti, exp_req, exp_vec, exp_ack, exp_do};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gie  = 1'b0;
        m_imr  = 8'h00;
        m_pend = 1'b0;
        m_vec  = 0;
        m_stk.delete();
        m_ack  = 8'h00;
        m_do   = 8'h00;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [7:0] q;
        logic [7:0] rd;
        int         w;
        bit         g;
        q = irq_in & m_imr;
        w = 8;
        for (int i = 7; i >= 0; i--) if (q[i]) w = i;
        rd = 8'h00;
        if (io_re) begin
            case (io_a)
                A_ICR:   rd = {m_gie, 7'd0};
                A_IMR:   rd = m_imr;
                A_IPR:   rd = q;
                A_IVR:   rd = (m_stk.size() > 0) ? (8'h80 | 8'(m_stk[$])) : 8'h00;
                default: rd = 8'h00;
            endcase
        end
        g = m_gie;
        if (io_we && io_a == A_ICR) g = io_di[7];
        m_ack = 8'h00;
        if (m_pend) begin
            if (cpu_irq_take) begin
                m_ack = 8'h01 << m_vec;
                m_stk.push_back(m_vec);
                m_pend = 1'b0;
                g = 1'b0;
            end else if (!q[m_vec] || !m_gie) begin
                m_pend = 1'b0;
            end
        end else if (m_stk.size() == 0) begin
            if (m_gie && q != 8'h00) begin
                m_pend = 1'b1;
                m_vec  = w;
            end
        end else if (cpu_reti) begin
            void'(m_stk.pop_back());
            g = 1'b1;
        end else if (m_gie && q != 8'h00 && w < m_stk[$] && m_stk.size() < MAXD) begin
            m_pend = 1'b1;
            m_vec  = w;
        end
        if (io_we && io_a == A_IMR) m_imr = io_di;
        m_gie = g;
        m_do  = rd;
    endtask

    task automatic step(input logic [5:0] a, input logic we, input logic re,
                        input logic [7:0] di, input logic [7:0] irq,
                        input logic take, input logic reti);
        io_a = a; io_we = we; io_re = re; io_di = di; irq_in = irq;
        cpu_irq_take = take; cpu_reti = reti;
        model_step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_model();
        chk("model_req", {7'd0, cpu_irq_req}, {7'd0, m_pend});
        if (m_pend) chk("model_vec", {5'd0, cpu_irq_vec}, 8'(m_vec));
        chk("model_ack", irq_ack, m_ack);
        chk("model_io_do", io_do, m_do);
    endtask

    task automatic do_reset();
        io_a = 6'd0; io_we = 1'b0; io_re = 1'b0; io_di = 8'h00; irq_in = 8'h00;
        cpu_irq_take = 1'b0; cpu_reti = 1'b0;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        // take+reti in IDLE ignored, then test plan 1..4 and REQ software-disable.
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_ICR, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_IMR, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_ICR, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 8'h00));
        tbl.push_back(mk(A_ICR, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_IVR, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h80));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_IVR, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_ICR, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h80));
        tbl.push_back(mk(A_IMR, 1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h06, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h06, 1'b1, 1'b0, 1'b0, 3'd0, 8'h02, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 3'd0, 8'h04, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_IMR, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h08, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_ICR, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_IMR, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_IPR, 1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h10));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_IPR, 1'b1, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_IMR, 1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF));
        tbl.push_back(mk(A_IPR, 1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h10));
        tbl.push_back(mk(A_ICR, 1'b1, 1'b0, 8'h80, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 8'h00));
        tbl.push_back(mk(A_ICR, 1'b1, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(A_IVR, 1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00));
        tbl.push_back(mk(6'd0,  1'b0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00));

        // Reset state (held in reset, then just after release).
        io_a = 6'd0; io_we = 1'b0; io_re = 1'b0; io_di = 8'h00; irq_in = 8'h00;
        cpu_irq_take = 1'b0; cpu_reti = 1'b0;
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_io_do", io_do, 8'h00);
        chk("rst_ack", irq_ack, 8'h00);
        chk("rst_req", {7'd0, cpu_irq_req}, 8'h00);
        chk("rst_vec", {5'd0, cpu_irq_vec}, 8'h00);
        sys_rst = 1'b0;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].a, tbl[i].we, tbl[i].re, tbl[i].di, tbl[i].irq,
                 tbl[i].take, tbl[i].reti);
            chk($sformatf("tbl%0d_req", i), {7'd0, cpu_irq_req}, {7'd0, tbl[i].exp_req});
            if (tbl[i].exp_req)
                chk($sformatf("tbl%0d_vec", i), {5'd0, cpu_irq_vec}, {5'd0, tbl[i].exp_vec});
            chk($sformatf("tbl%0d_ack", i), irq_ack, tbl[i].exp_ack);
            chk($sformatf("tbl%0d_io_do", i), io_do, tbl[i].exp_do);
        end

        // Reset asserted between take and ack: ack must never appear, registers clear.
        do_reset();
        step(A_IMR, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
        step(A_ICR, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0);
        step(6'd0,  1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        chk("rst5_req_before", {7'd0, cpu_irq_req}, 8'h01);
        io_we = 1'b0; cpu_irq_take = 1'b1;
        #2 sys_rst = 1'b1;
        #1;
        chk("rst5_req_async", {7'd0, cpu_irq_req}, 8'h00);
        chk("rst5_ack_async", irq_ack, 8'h00);
        @(posedge sys_clk);
        #1;
        chk("rst5_ack_edge", irq_ack, 8'h00);
        sys_rst = 1'b0; cpu_irq_take = 1'b0;
        model_reset();
        step(A_ICR, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
        chk("rst5_icr", io_do, 8'h00);
        chk("rst5_ack_after", irq_ack, 8'h00);
        step(A_IMR, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
        chk("rst5_imr", io_do, 8'h00);
        step(A_IPR, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
        chk("rst5_ipr", io_do, 8'h00);
        step(A_IVR, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
        chk("rst5_ivr", io_do, 8'h00);
        chk("rst5_req_after", {7'd0, cpu_irq_req}, 8'h00);

`ifdef IRQ_NEST_EN
        // Nested service: vec 5 in service, software re-enables, vec 2 preempts.
        do_reset();
        step(A_IMR, 1'b1, 1'b0, 8'h24, 8'h00, 1'b0, 1'b0);
        step(A_ICR, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0);
        step(6'd0,  1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0);
        chk("nest_req5", {4'd0, cpu_irq_req, cpu_irq_vec}, 8'h0D);
        step(6'd0,  1'b0, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0);
        chk("nest_ack5", irq_ack, 8'h20);
        step(A_ICR, 1'b1, 1'b0, 8'h80, 8'h20, 1'b0, 1'b0);
        step(6'd0,  1'b0, 1'b0, 8'h00, 8'h24, 1'b0, 1'b0);
        chk("nest_req2", {4'd0, cpu_irq_req, cpu_irq_vec}, 8'h0A);
        step(6'd0,  1'b0, 1'b0, 8'h00, 8'h24, 1'b1, 1'b0);
        chk("nest_ack2", irq_ack, 8'h04);
        step(A_IVR, 1'b0, 1'b1, 8'h00, 8'h04, 1'b0, 1'b0);
        chk("nest_ivr2", io_do, 8'h82);
        step(6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(A_IVR, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("nest_ivr5", io_do, 8'h85);
        step(6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(A_IVR, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("nest_ivr_idle", io_do, 8'h00);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        begin
            logic [7:0] lvl;
            logic [5:0] ra;
            logic       rwe, rre;
            lvl = 8'h00;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 3) == 0) lvl = 8'($urandom);
                rwe = ($urandom_range(0, 7) == 0);
                rre = ($urandom_range(0, 2) == 0);
                ra  = rwe ? 6'(6'h20 + 6'($urandom_range(0, 3)))
                          : 6'($urandom_range(6'h1E, 6'h25));
                step(ra, rwe, rre, 8'($urandom), lvl,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
                check_model();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
